// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit feeding HI/LO, with a busy flag for hazard stalls.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [63:0]      res;
  logic             op_valid;
  logic             is_div;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] p;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    p  = ax * bx;
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Results are packed {remainder, quotient} so they drop straight into {hi, lo}.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {32'd0, 32'h8000_0000};
    end else begin
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  always_comb begin
    op_valid = 1'b0;
    is_div   = 1'b0;
    res      = 64'd0;
    case (op)
      3'd0: begin op_valid = 1'b1; res = mul_s(D1, D2); end
      3'd1: begin op_valid = 1'b1; res = mul_u(D1, D2); end
      3'd2: begin op_valid = 1'b1; is_div = 1'b1; res = div_s(D1, D2); end
      3'd3: begin op_valid = 1'b1; is_div = 1'b1; res = div_u(D1, D2); end
`ifdef MDU_MADD_EN
      3'd4: begin op_valid = 1'b1; res = {hi, lo} + mul_s(D1, D2); end
      3'd5: begin op_valid = 1'b1; res = {hi, lo} + mul_u(D1, D2); end
`endif
      default: ;
    endcase
  end

  // Result is computed at launch and held in pend_* until the countdown expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
      end
    end else if (start) begin
      if (op_valid) begin
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
        busy    <= 1'b1;
      end
    end else begin
      if (mthi) hi <= D1;
      if (mtlo) lo <= D1;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: multiply/divide results, busy timing, MTHI/MTLO, reset abort.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int nb;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .D1(D1), .D2(D2),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; D1 = a; D2 = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic write_hilo(input logic h, input logic l, input logic [31:0] v);
    mthi = h; mtlo = l; D1 = v;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; D1 = 32'd0; D2 = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MULT -2 * 3
    launch(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(nb);
    check("mult_busy_cycles", nb, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max, old hi/lo held while busy
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_now", {31'd0, busy}, 32'd1);
    check("multu_hold_hi", hi, 32'hFFFF_FFFF);
    check("multu_hold_lo", lo, 32'hFFFF_FFFA);
    wait_idle(nb);
    check("multu_busy_cycles", nb, 32'd5);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2
    launch(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(nb);
    check("div_busy_cycles", nb, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU by zero
    launch(3'd3, 32'h0000_1234, 32'd0);
    wait_idle(nb);
    check("divu0_busy_cycles", nb, 32'd10);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_1234);

    // DIV signed overflow
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0000_0000);

    // start while busy is ignored
    launch(3'd0, 32'd7, 32'd6);
    op = 3'd3; D1 = 32'd100; D2 = 32'd3;
    nb = 0;
    while (busy === 1'b1 && nb < 50) begin
      nb++;
      start = (nb == 2);
      tick();
    end
    start = 1'b0;
    check("restart_busy_cycles", nb, 32'd5);
    check("restart_hi", hi, 32'd0);
    check("restart_lo", lo, 32'd42);
    tick();
    check("restart_no_relaunch", {31'd0, busy}, 32'd0);

    // MTHI in idle
    write_hilo(1'b1, 1'b0, 32'hA5A5_A5A5);
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo_kept", lo, 32'd42);

    // DIV launched together with mtlo: mtlo dropped
    op = 3'd2; D1 = 32'd100; D2 = 32'd7; start = 1'b1; mtlo = 1'b1;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_ignored_lo", lo, 32'd42);
    wait_idle(nb);
    check("div_mtlo_busy_cycles", nb, 32'd10);
    check("div_mtlo_lo", lo, 32'd14);
    check("div_mtlo_hi", hi, 32'd2);

    // mthi and mtlo together
    write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
    check("mtboth_hi", hi, 32'hCAFE_F00D);
    check("mtboth_lo", lo, 32'hCAFE_F00D);

    // op 6 is a no-op
    launch(3'd6, 32'd9, 32'd9);
    check("op6_busy", {31'd0, busy}, 32'd0);
    check("op6_hi", hi, 32'hCAFE_F00D);
    check("op6_lo", lo, 32'hCAFE_F00D);

`ifdef MDU_MADD_EN
    write_hilo(1'b1, 1'b0, 32'h0000_0000);
    write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
    launch(3'd5, 32'd1, 32'd1);
    wait_idle(nb);
    check("maddu_busy_cycles", nb, 32'd5);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`else
    launch(3'd4, 32'd1, 32'd1);
    check("op4_busy", {31'd0, busy}, 32'd0);
    check("op4_hi", hi, 32'hCAFE_F00D);
    check("op4_lo", lo, 32'hCAFE_F00D);
`endif

    // Reset during the 3rd busy cycle of a MULT
    launch(3'd0, 32'd3, 32'd5);
    tick(); tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_no_commit_lo", lo, 32'd0);
    check("abort_no_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) and performs MULT/MULTU/DIV/DIVU with multi-cycle latency into the HI/LO registers.
- Supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Drives a busy flag so the hazard unit can stall dependent instructions.

Parameters:
- MULT_CYCLES, 5, number of cycles busy is high for a multiply (must be >= 1).
- DIV_CYCLES, 10, number of cycles busy is high for a divide (must be >= 1).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  synchronous active-high reset.
- start  input  1  launch operation selected by op, sampled on the rising edge.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4..7 see Optional Feature.
- D1  input  32  rs operand (dividend / multiplicand; MTHI/MTLO source).
- D2  input  32  rt operand (divisor / multiplier).
- mthi  input  1  write D1 to HI.
- mtlo  input  1  write D1 to LO.
- busy  output  1  operation in progress.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. On a reset edge:
  - busy=0, hi=0, lo=0.
  - Internal counter and pending-result registers are cleared.
  - Reset takes priority over all other inputs, including mid-operation; the in-flight result is discarded.
- States are IDLE and BUSY. The state is encoded as busy plus a down-counter cnt, which is wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE with start=1 and a valid op:
  - On the edge, compute and latch the 64-bit result into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1.
- BUSY:
  - Each edge decrements cnt.
  - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, busy<=0.
  - Net effect: busy is high for exactly N cycles, starting the cycle after start.
  - New hi/lo values are visible in the first cycle with busy=0.
- Multiply:
  - MULT: signed 32x32 to 64. MULTU: unsigned. hi = bits[63:32], lo = bits[31:0].
- Divide:
  - lo = quotient, hi = remainder.
  - DIV is signed: the quotient truncates toward zero and the remainder takes the sign of the dividend. DIVU is unsigned.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divide by zero (D2=0), for DIV and DIVU: lo=0xFFFFFFFF, hi=D1. Busy timing is unchanged.
- start while busy=1: ignored. No restart occurs and the pending result is unaffected.
- mthi/mtlo:
  - Take effect on the edge only when busy=0 and start=0.
  - When busy=1 or start=1 they are ignored; the pipeline is required to stall.
  - mthi and mtlo together: both are written with D1.
- start=1 with an op code that is not enabled: treated as a no-op. busy stays 0 and hi/lo are unchanged.
- hi/lo outputs are direct register outputs, with no combinational bypass from D1.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 4=MADD (signed) and op 5=MADDU (unsigned) are enabled, with latency MULT_CYCLES.
  - The 64-bit {hi,lo} sampled at start is added to D1*D2, wrapping modulo 2^64.
  - The result commits exactly as for MULT.
- Not defined: ops 4..7 are no-ops, with no busy and no state change.
- Ops 6 and 7 are no-ops in both builds.

Test Plan:
- Reset, then MULT with D1=0xFFFFFFFE (-2), D2=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with D1=0xFFFFFFFF, D2=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001; hi/lo hold their old values while busy.
- DIV with D1=0xFFFFFFF9 (-7), D2=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Three cases, each checked separately:
  - DIVU with D2=0, D1=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Start during busy -> ignored, first result commits unchanged.
- MTHI with D1=0xA5A5A5A5 in idle -> hi=0xA5A5A5A5 next cycle. Then start DIV and assert mtlo in the same cycle -> mtlo ignored and the DIV result is committed.
- Reset asserted on the 3rd busy cycle of a MULT -> busy=0, hi=lo=0 next cycle, and no later commit. With MDU_MADD_EN: hi:lo=0x00000000_FFFFFFFF, MADDU 1*1 -> hi=1, lo=0.
